// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: redirect encodings,
// instruction size and the width helper used for occupancy counters.
package fetch_pkg;

   typedef enum logic [1:0] {
      REDIR_NONE   = 2'd0,
      REDIR_BRANCH = 2'd1,
      REDIR_JUMP   = 2'd2,
      REDIR_REG    = 2'd3
   } redir_kind_e;

   // Every fetch advances the PC by one instruction word.
   localparam int INST_BYTES = 4;

   // A counter that must hold 0..depth inclusive needs one bit more than
   // the pointer width.
   function automatic int countWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between the
// instruction memory and decode. DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              din,
   output logic [WIDTH-1:0]              dout,
   output logic [countWidth(DEPTH)-1:0]  count,
   output logic                          full,
   output logic                          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = countWidth(DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rdPtr;
   logic [PW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // A flush wins over any push or pop in the same cycle, and requests
   // that would overflow or underflow are ignored.
   assign w_push = push & ~full & ~flush & ~reset;
   assign w_pop  = pop & ~empty & ~flush & ~reset;

   assign full  = (r_count == FULL_COUNT);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rdPtr];

   // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Entry storage carries no reset; only slots behind the pointers are read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= din;
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues one sequential request per
// cycle to a single-cycle-latency instruction memory, buffers returned words
// with their PCs in a prefetch queue, and handles control-flow redirects.
// An epoch bit tags each outstanding request so responses belonging to a
// path abandoned by a redirect are discarded. ADDR_W must be at least 27
// so both signed offsets sign-extend into the PC width.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pc_enable,
   output logic                           imem_req_valid,
   output logic [ADDR_W-1:0]              imem_req_addr,
   input  logic                           imem_resp_valid,
   input  logic [INST_W-1:0]              imem_resp_data,
   input  logic [1:0]                     redir_kind,
   input  logic [ADDR_W-1:0]              redir_base_pc,
   input  logic [15:0]                    redir_imm16,
   input  logic [25:0]                    redir_imm26,
   input  logic [ADDR_W-1:0]              redir_reg,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INST_W-1:0]              out_inst,
   output logic [ADDR_W-1:0]              out_pc,
   output logic [countWidth(QDEPTH)-1:0]  q_count
);

   localparam int CW = countWidth(QDEPTH);
   localparam int EW = ADDR_W + INST_W;
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(QDEPTH);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflightPc;
   logic              r_epoch;
   logic              r_inflight;
   logic              r_inflightEpoch;

   redir_kind_e       w_kind;
   logic              w_redirect;
   logic [ADDR_W-1:0] w_target;
   logic [CW:0]       w_committed;
   logic              w_accept;
   logic              w_pop;
   logic [EW-1:0]     w_fifoDin;
   logic [EW-1:0]     w_fifoDout;
   logic [CW-1:0]     w_count;
   logic              w_fifoFull;
   logic              w_fifoEmpty;

   assign w_kind     = redir_kind_e'(redir_kind);
   assign w_redirect = (w_kind != REDIR_NONE);

   // Redirect target: offsets are signed byte offsets added to the PC of
   // the redirecting instruction; the sum simply wraps at ADDR_W bits.
   always_comb begin
      w_target = r_pc;
      case (w_kind)
         REDIR_BRANCH: w_target = redir_base_pc + {{(ADDR_W-16){redir_imm16[15]}}, redir_imm16};
         REDIR_JUMP:   w_target = redir_base_pc + {{(ADDR_W-26){redir_imm26[25]}}, redir_imm26};
         REDIR_REG:    w_target = redir_reg;
         default:      w_target = r_pc;
      endcase
   end

   // Queue slots already spoken for: stored entries plus the one response
   // that may still be on its way back. Issuing only below QDEPTH means a
   // returning response always finds room.
   assign w_committed    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign imem_req_valid = pc_enable & ~reset & ~w_redirect & (w_committed < CREDIT_LIMIT);
   assign imem_req_addr  = r_pc;

   // A response is kept only if it belongs to the current path.
   assign w_accept  = imem_resp_valid & r_inflight & (r_inflightEpoch == r_epoch)
                      & ~w_redirect & ~reset & ~w_fifoFull;
   assign w_pop     = out_valid & out_ready & ~w_redirect & ~reset;
   assign w_fifoDin = {r_inflightPc, imem_resp_data};

   // PC and epoch: reset beats redirect, which beats sequential advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_epoch <= 1'b0;
      end else if (w_redirect) begin
         r_pc    <= w_target;
         r_epoch <= ~r_epoch;
      end else if (imem_req_valid) begin
         r_pc <= r_pc + ADDR_W'(INST_BYTES);
      end
   end

   // Remember the single outstanding request for exactly one cycle, along
   // with the PC it fetched and the epoch it was issued under.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight      <= 1'b0;
         r_inflightEpoch <= 1'b0;
         r_inflightPc    <= '0;
      end else begin
         r_inflight      <= imem_req_valid;
         r_inflightEpoch <= r_epoch;
         r_inflightPc    <= r_pc;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (w_redirect),
      .push  (w_accept),
      .pop   (w_pop),
      .din   (w_fifoDin),
      .dout  (w_fifoDout),
      .count (w_count),
      .full  (w_fifoFull),
      .empty (w_fifoEmpty)
   );

   assign out_valid = ~w_fifoEmpty;
   assign out_pc    = w_fifoDout[EW-1:INST_W];
   assign out_inst  = w_fifoDout[INST_W-1:0];
   assign q_count   = w_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit. A behavioural model (PC value, a queue of
// {pc, inst} pairs and one pending-request slot) predicts every cycle's
// outputs; directed scenarios add their own explicit checks. A second
// instance with a high reset PC exercises address wrap-around.
module tb_fetch_queue_unit;
   import fetch_pkg::*;

   localparam int          QDEPTH  = 4;
   localparam int          CW      = $clog2(QDEPTH) + 1;
   localparam logic [31:0] SALT    = 32'hA5A5_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic          reset = 1'b1;
   logic          pcEnable = 1'b0;
   logic          reqValid;
   logic [31:0]   reqAddr;
   logic          respValid = 1'b0;
   logic [31:0]   respData = '0;
   logic [1:0]    redirKind = 2'd0;
   logic [31:0]   redirBasePc = '0;
   logic [15:0]   redirImm16 = '0;
   logic [25:0]   redirImm26 = '0;
   logic [31:0]   redirReg = '0;
   logic          outValid;
   logic          outReady = 1'b0;
   logic [31:0]   outInst;
   logic [31:0]   outPc;
   logic [CW-1:0] qCount;

   // wrap instance
   logic          wReset = 1'b1;
   logic          wEnable = 1'b0;
   logic          wReqValid;
   logic [31:0]   wReqAddr;
   logic          wRespValid = 1'b0;
   logic [31:0]   wRespData = '0;
   logic          wOutValid;
   logic [31:0]   wOutInst;
   logic [31:0]   wOutPc;
   logic [CW-1:0] wQCount;

   int assertCount = 0;
   int failCount = 0;

   // reference model state
   logic [31:0] mPc = '0;
   logic [63:0] mQueue[$];
   logic        mPendValid = 1'b0;
   logic [31:0] mPendPc = '0;

   // memory model: remembers last cycle's request to answer it
   logic        lastReqValid = 1'b0;
   logic [31:0] lastReqAddr = '0;
   logic        wLastReqValid = 1'b0;
   logic [31:0] wLastReqAddr = '0;

   fetch_queue_unit #(
      .ADDR_W(32), .INST_W(32), .QDEPTH(QDEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .reset(reset), .pc_enable(pcEnable),
      .imem_req_valid(reqValid), .imem_req_addr(reqAddr),
      .imem_resp_valid(respValid), .imem_resp_data(respData),
      .redir_kind(redirKind), .redir_base_pc(redirBasePc),
      .redir_imm16(redirImm16), .redir_imm26(redirImm26), .redir_reg(redirReg),
      .out_valid(outValid), .out_ready(outReady), .out_inst(outInst),
      .out_pc(outPc), .q_count(qCount)
   );

   fetch_queue_unit #(
      .ADDR_W(32), .INST_W(32), .QDEPTH(QDEPTH), .RESET_PC(WRAP_PC)
   ) dutWrap (
      .clk(clk), .reset(wReset), .pc_enable(wEnable),
      .imem_req_valid(wReqValid), .imem_req_addr(wReqAddr),
      .imem_resp_valid(wRespValid), .imem_resp_data(wRespData),
      .redir_kind(2'd0), .redir_base_pc(32'h0),
      .redir_imm16(16'h0), .redir_imm26(26'h0), .redir_reg(32'h0),
      .out_valid(wOutValid), .out_ready(1'b1), .out_inst(wOutInst),
      .out_pc(wOutPc), .q_count(wQCount)
   );

   // One clock cycle: answer last cycle's requests, compare the main DUT with
   // the model just before the edge, then advance the model across the edge.
   task automatic step(input bit doCheck);
      logic        expReq;
      logic        redir;
      logic [31:0] target;
      int          sz;
      respValid  = lastReqValid;
      respData   = lastReqAddr ^ SALT;
      wRespValid = wLastReqValid;
      wRespData  = wLastReqAddr ^ SALT;
      #1;
      redir  = (redirKind != 2'd0);
      sz     = mQueue.size();
      expReq = pcEnable && !reset && !redir && ((sz + (mPendValid ? 1 : 0)) < QDEPTH);
      if (doCheck) begin
         assertCount++;
         if (reqValid !== expReq) begin
            failCount++;
            $display("[TB] FAIL req_valid: got %b want %b at %0t", reqValid, expReq, $time);
         end
         if (expReq) begin
            assertCount++;
            if (reqAddr !== mPc) begin
               failCount++;
               $display("[TB] FAIL req_addr: got %h want %h at %0t", reqAddr, mPc, $time);
            end
         end
         assertCount++;
         if (outValid !== (sz > 0)) begin
            failCount++;
            $display("[TB] FAIL out_valid: got %b want %b at %0t", outValid, (sz > 0), $time);
         end
         if (sz > 0) begin
            assertCount++;
            if ({outPc, outInst} !== mQueue[0]) begin
               failCount++;
               $display("[TB] FAIL out_head: got %h/%h want %h/%h at %0t",
                        outPc, outInst, mQueue[0][63:32], mQueue[0][31:0], $time);
            end
         end
         assertCount++;
         if (qCount !== CW'(sz)) begin
            failCount++;
            $display("[TB] FAIL q_count: got %0d want %0d at %0t", qCount, sz, $time);
         end
         if (!reset && !redir && respValid && mPendValid) begin
            assertCount++;
            if ((qCount >= CW'(QDEPTH)) && !(outValid && outReady)) begin
               failCount++;
               $display("[TB] FAIL enqueue_into_full: q_count %0d limit %0d at %0t",
                        qCount, QDEPTH, $time);
            end
         end
      end
      lastReqValid  = reqValid;
      lastReqAddr   = reqAddr;
      wLastReqValid = wReqValid;
      wLastReqAddr  = wReqAddr;
      @(posedge clk);
      if (reset) begin
         mPc = 32'h0;
         mQueue.delete();
         mPendValid = 1'b0;
      end else if (redir) begin
         case (redirKind)
            2'd1:    target = redirBasePc + {{16{redirImm16[15]}}, redirImm16};
            2'd2:    target = redirBasePc + {{6{redirImm26[25]}}, redirImm26};
            default: target = redirReg;
         endcase
         mPc = target;
         mQueue.delete();
         mPendValid = 1'b0;
      end else begin
         if (sz > 0 && outReady) begin
            void'(mQueue.pop_front());
         end
         if (respValid && mPendValid) begin
            mQueue.push_back({mPendPc, respData});
         end
         mPendValid = expReq;
         mPendPc    = mPc;
         if (expReq) begin
            mPc = mPc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      redirKind = 2'd0;
      step(1'b1);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b0);
      step(1'b1);
      assertCount++;
      if (qCount !== '0 || outValid !== 1'b0 || reqValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_state: q_count %0d out_valid %b req_valid %b want 0 0 0",
                  qCount, outValid, reqValid);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      doReset();
      pcEnable = 1'b1;
      outReady = 1'b1;
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'h0) begin
         failCount++;
         $display("[TB] FAIL stream_first_req: got %b/%h want 1/00000000", lastReqValid, lastReqAddr);
      end
      step(1'b1);
      assertCount++;
      if (outValid !== 1'b1 || outPc !== 32'h0 || outInst !== SALT) begin
         failCount++;
         $display("[TB] FAIL stream_first_out: got %b/%h/%h want 1/00000000/%h",
                  outValid, outPc, outInst, SALT);
      end
      for (int k = 1; k <= 8; k++) begin
         step(1'b1);
         assertCount++;
         if (outValid !== 1'b1 || outPc !== 32'(4 * k) || outInst !== (32'(4 * k) ^ SALT)) begin
            failCount++;
            $display("[TB] FAIL stream_rate: got %b/%h want 1/%h", outValid, outPc, 32'(4 * k));
         end
      end
   endtask

   task automatic test_backpressure();
      int          issued;
      logic        seenResume;
      doReset();
      pcEnable = 1'b1;
      outReady = 1'b0;
      issued = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1);
         if (lastReqValid) begin
            assertCount++;
            if (lastReqAddr !== 32'(4 * issued)) begin
               failCount++;
               $display("[TB] FAIL bp_addr: got %h want %h", lastReqAddr, 32'(4 * issued));
            end
            issued++;
         end
      end
      assertCount++;
      if (issued != 4 || qCount !== CW'(4) || reqValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL bp_stall: issued %0d q_count %0d req %b want 4 4 0", issued, qCount, reqValid);
      end
      outReady = 1'b1;
      seenResume = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step(1'b1);
         if (lastReqValid && !seenResume) begin
            seenResume = 1'b1;
            assertCount++;
            if (lastReqAddr !== 32'h10) begin
               failCount++;
               $display("[TB] FAIL bp_resume: got %h want 00000010", lastReqAddr);
            end
         end
      end
   endtask

   task automatic test_branch();
      doReset();
      pcEnable = 1'b1;
      outReady = 1'b1;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      redirKind = 2'd1;
      redirBasePc = 32'h100;
      redirImm16 = 16'hFFF0;
      step(1'b1);
      redirKind = 2'd0;
      assertCount++;
      if (qCount !== '0) begin
         failCount++;
         $display("[TB] FAIL branch_flush: q_count %0d want 0", qCount);
      end
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'hF0) begin
         failCount++;
         $display("[TB] FAIL branch_target: got %b/%h want 1/000000f0", lastReqValid, lastReqAddr);
      end
      step(1'b1);
      assertCount++;
      if (outValid !== 1'b1 || outPc !== 32'hF0) begin
         failCount++;
         $display("[TB] FAIL branch_first_out: got %b/%h want 1/000000f0", outValid, outPc);
      end
   endtask

   task automatic test_jump();
      doReset();
      pcEnable = 1'b1;
      outReady = 1'b1;
      step(1'b1);
      step(1'b1);
      redirKind = 2'd2;
      redirBasePc = 32'h10;
      redirImm26 = 26'h0000040;
      step(1'b1);
      redirKind = 2'd0;
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'h50) begin
         failCount++;
         $display("[TB] FAIL jump_target: got %b/%h want 1/00000050", lastReqValid, lastReqAddr);
      end
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'h54) begin
         failCount++;
         $display("[TB] FAIL jump_seq: got %b/%h want 1/00000054", lastReqValid, lastReqAddr);
      end
      redirKind = 2'd3;
      redirReg = 32'hDEAD_BEE0;
      step(1'b1);
      redirKind = 2'd0;
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'hDEAD_BEE0) begin
         failCount++;
         $display("[TB] FAIL regjump_target: got %b/%h want 1/deadbee0", lastReqValid, lastReqAddr);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         assertCount++;
         if (outValid && outPc === 32'h54) begin
            failCount++;
            $display("[TB] FAIL regjump_stale: got out_pc %h want anything but 00000054", outPc);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] expAddr [3];
      expAddr[0] = 32'hFFFF_FFF8;
      expAddr[1] = 32'hFFFF_FFFC;
      expAddr[2] = 32'h0000_0000;
      pcEnable = 1'b0;
      wReset = 1'b1;
      step(1'b1);
      wReset = 1'b0;
      wEnable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b1);
         assertCount++;
         if (!wLastReqValid || wLastReqAddr !== expAddr[k]) begin
            failCount++;
            $display("[TB] FAIL wrap_addr%0d: got %b/%h want 1/%h", k, wLastReqValid, wLastReqAddr, expAddr[k]);
         end
      end
      assertCount++;
      if (wOutValid !== 1'b1 || wOutPc !== 32'hFFFF_FFFC || wOutInst !== (32'hFFFF_FFFC ^ SALT)) begin
         failCount++;
         $display("[TB] FAIL wrap_out: got %b/%h/%h want 1/fffffffc", wOutValid, wOutPc, wOutInst);
      end
      wEnable = 1'b0;
   endtask

   task automatic test_reset_midstream();
      doReset();
      pcEnable = 1'b1;
      outReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
      end
      reset = 1'b1;
      step(1'b1);
      assertCount++;
      if (outValid !== 1'b0 || qCount !== '0 || reqValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midreset_clear: got %b/%0d/%b want 0/0/0", outValid, qCount, reqValid);
      end
      reset = 1'b0;
      outReady = 1'b1;
      step(1'b1);
      assertCount++;
      if (!lastReqValid || lastReqAddr !== 32'h0 || outValid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midreset_restart: got req %b/%h out_valid %b want 1/00000000 0",
                  lastReqValid, lastReqAddr, outValid);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
      end
   endtask

   task automatic test_random();
      doReset();
      for (int k = 0; k < 500; k++) begin
         pcEnable = ($urandom_range(0, 9) < 8);
         outReady = ($urandom_range(0, 1) == 1);
         reset    = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 99) < 8) begin
            redirKind   = 2'($urandom_range(1, 3));
            redirBasePc = $urandom();
            redirImm16  = 16'($urandom());
            redirImm26  = 26'($urandom());
            redirReg    = $urandom();
         end else begin
            redirKind = 2'd0;
         end
         step(1'b1);
      end
      reset = 1'b0;
      redirKind = 2'd0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_jump();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
